// File: rtl/maple_rx.sv
// maple_rx - Maple bus frame receiver/decoder.
//
// Watches the selected port's pin1 (SDCKA) and pin5 (SDCKB) levels. It
// recognises the start pattern (pin1 low, four pin5 falls, pin1 high). It
// decodes the alternating-phase data bits into bytes:
//   - phase A clocks on a pin1 fall and takes pin5 as the data bit;
//   - phase B clocks on a pin5 fall and takes pin1 as the data bit.
// It recognises the end pattern (pin5 low, two pin1 falls, pin5 high).
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   enable       1 = receive, 0 = hold in IDLE (local side is transmitting)
//   in_p1/in_p5  raw asynchronous pin1/pin5 levels
//   rx_data      last completed byte (MSB first on the wire), held until the next
//   rx_valid     1-cycle pulse when rx_data is updated
//   frame_start  1-cycle pulse on a valid start pattern
//   frame_end    1-cycle pulse on a valid end pattern at a byte boundary
//   frame_error  1-cycle pulse on a framing violation or an in-frame timeout
//   busy         receiver is not in IDLE
//
// Pipeline: SYNC_STAGES synchronizer flops, then one edge-detect register,
// then the FSM register. A raw wire edge therefore reaches a pulse output
// SYNC_STAGES+2 cycles later.
module maple_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMO_W          = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       in_p1,
  input  logic       in_p5,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_END
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  // Synchronizers. They reset to 1 because the idle bus is high.
  logic [SYNC_STAGES-1:0] sync1_reg, sync5_reg;
  logic a1, a5;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync5_reg <= '1;
    end else begin
      sync1_reg <= {sync1_reg[SYNC_STAGES-2:0], in_p1};
      sync5_reg <= {sync5_reg[SYNC_STAGES-2:0], in_p5};
    end
  end

  assign a1 = sync1_reg[SYNC_STAGES-1];
  assign a5 = sync5_reg[SYNC_STAGES-1];

  // Registered edge flags. Each flag is captured together with both line
  // levels from the same cycle, so the FSM always sees a coherent snapshot.
  logic a1_prev_reg, a5_prev_reg;
  logic fall1_reg, fall5_reg, rise1_reg, rise5_reg;
  logic lvl1_reg, lvl5_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1_prev_reg <= 1'b1;
      a5_prev_reg <= 1'b1;
      fall1_reg   <= 1'b0;
      fall5_reg   <= 1'b0;
      rise1_reg   <= 1'b0;
      rise5_reg   <= 1'b0;
      lvl1_reg    <= 1'b1;
      lvl5_reg    <= 1'b1;
    end else begin
      a1_prev_reg <= a1;
      a5_prev_reg <= a5;
      fall1_reg   <= a1_prev_reg & ~a1;
      fall5_reg   <= a5_prev_reg & ~a5;
      rise1_reg   <= ~a1_prev_reg & a1;
      rise5_reg   <= ~a5_prev_reg & a5;
      lvl1_reg    <= a1;
      lvl5_reg    <= a5;
    end
  end

  logic any_edge;
  assign any_edge = fall1_reg | fall5_reg | rise1_reg | rise5_reg;

  // Receiver FSM and datapath.
  state_t           state_reg;
  logic [2:0]       pcnt_reg;     // pin5 falls seen in START (saturates at 7)
  logic [1:0]       ecnt_reg;     // pin1 falls seen in END (saturates at 3)
  logic [2:0]       bitcnt_reg;   // bits in the current byte; wraps 7->0
  logic             expect_b_reg; // 0: next bit is phase A, 1: phase B
  logic [7:0]       shift_reg;
  logic [TMO_W-1:0] tmo_reg;

  // The data line for the expected phase, appended to the shift register.
  logic       data_bit;
  logic [7:0] shifted;
  assign data_bit = expect_b_reg ? lvl1_reg : lvl5_reg;
  assign shifted  = {shift_reg[6:0], data_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      pcnt_reg     <= '0;
      ecnt_reg     <= '0;
      bitcnt_reg   <= '0;
      expect_b_reg <= 1'b0;
      shift_reg    <= '0;
      tmo_reg      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;

      if (!enable) begin
        // The local side owns the bus. Drop any frame without reporting it.
        state_reg <= S_IDLE;
        tmo_reg   <= '0;
      end else begin
        if (state_reg == S_IDLE || any_edge) begin
          tmo_reg <= '0;
        end else begin
          tmo_reg <= tmo_reg + TMO_ONE;
        end

        // A timeout can only fire in a cycle with no edge, so it never
        // competes with a decoded event.
        if (state_reg != S_IDLE && !any_edge && tmo_reg == TMO_LAST) begin
          frame_error <= 1'b1;
          state_reg   <= S_IDLE;
        end else begin
          case (state_reg)
            S_IDLE: begin
              if (fall1_reg && lvl5_reg) begin
                state_reg <= S_START;
                pcnt_reg  <= '0;
              end
            end

            S_START: begin
              if (rise1_reg) begin
                if (pcnt_reg == 3'd4) begin
                  state_reg    <= S_DATA;
                  frame_start  <= 1'b1;
                  bitcnt_reg   <= '0;
                  expect_b_reg <= 1'b0;
                end else begin
                  frame_error <= 1'b1;
                  state_reg   <= S_IDLE;
                end
              end else if (fall5_reg && pcnt_reg != 3'd7) begin
                pcnt_reg <= pcnt_reg + 3'd1;
              end
            end

            S_DATA: begin
              if (fall1_reg && fall5_reg) begin
                frame_error <= 1'b1;
                state_reg   <= S_IDLE;
              end else if ((fall1_reg && !expect_b_reg) ||
                           (fall5_reg && expect_b_reg)) begin
                shift_reg    <= shifted;
                bitcnt_reg   <= bitcnt_reg + 3'd1;
                expect_b_reg <= ~expect_b_reg;
                if (bitcnt_reg == 3'd7) begin
                  rx_data  <= shifted;
                  rx_valid <= 1'b1;
                end
              end else if (fall5_reg) begin
                // pin5 falls while phase A is expected. This is an end
                // marker only on a byte boundary with pin1 high.
                if (bitcnt_reg == 3'd0 && lvl1_reg) begin
                  state_reg <= S_END;
                  ecnt_reg  <= '0;
                end else begin
                  frame_error <= 1'b1;
                  state_reg   <= S_IDLE;
                end
              end else if (fall1_reg) begin
                // pin1 falls while phase B is expected: the phases are out of order.
                frame_error <= 1'b1;
                state_reg   <= S_IDLE;
              end
            end

            S_END: begin
              if (rise5_reg) begin
                if (ecnt_reg == 2'd2) begin
                  frame_end <= 1'b1;
                end else begin
                  frame_error <= 1'b1;
                end
                state_reg <= S_IDLE;
              end else if (fall1_reg && ecnt_reg != 2'd3) begin
                ecnt_reg <= ecnt_reg + 2'd1;
              end
            end

            default: state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_maple_rx.sv
// tb_maple_rx - self-checking bench for maple_rx.
//
// Stimulus tasks drive wire-level Maple patterns. Each task pushes the pulses
// it expects onto a scoreboard queue. A monitor on the falling clock edge
// pops the queue and compares every pulse the DUT produces. Simple frames come
// from a vector table. Timeout, enable and reset use hand-written sequences.
module tb_maple_rx;

  localparam int S    = 2;
  localparam int T    = 256;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       in_p1 = 1'b1;
  logic       in_p5 = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_start, frame_end, frame_error, busy;

  maple_rx #(
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(T),
    .TMO_W         (13)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .in_p1      (in_p1),
    .in_p5      (in_p5),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_START, EV_BYTE, EV_END, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_valid_cyc = -1;
  int  last_err_cyc = -1;

  function automatic string ev_name(input ev_kind_t k);
    case (k)
      EV_START: return "frame_start";
      EV_BYTE:  return "rx_valid";
      EV_END:   return "frame_end";
      default:  return "frame_error";
    endcase
  endfunction

  task automatic push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got %s data=0x%02h, required no pulse", ev_name(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
        errors++;
        $display("FAIL event_order: got %s data=0x%02h, required %s data=0x%02h",
                 ev_name(k), d, ev_name(e.kind), e.data);
      end else begin
        $display("[%0d] %s data=0x%02h as expected", cyc, ev_name(k), d);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pulse monitor: at most one pulse per cycle. Every pulse must match the
  // head of the scoreboard.
  always @(negedge clk) begin : mon
    int n;
    n = int'(rx_valid) + int'(frame_start) + int'(frame_end) + int'(frame_error);
    if (n > 0) begin
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL onehot_pulses: got %0d pulses in one cycle, required 1", n);
      end
      if (frame_start) check_event(EV_START, 8'h00);
      if (rx_valid) begin
        last_valid_cyc = cyc;
        check_event(EV_BYTE, rx_data);
      end
      if (frame_end) check_event(EV_END, 8'h00);
      if (frame_error) begin
        last_err_cyc = cyc;
        check_event(EV_ERR, 8'h00);
      end
    end
  end

  // Wire-level drivers. Each level is held for HOLD cycles.
  task automatic set_lines(input logic v1, input logic v5);
    @(posedge clk);
    #1;
    in_p1 = v1;
    in_p5 = v5;
    repeat (HOLD - 1) @(posedge clk);
  endtask

  // pin1 low, then n pin5 falls, then pin1 high. pin5 stays low after the
  // last fall, so the first data bit never needs a pin5 fall to set up.
  task automatic send_start(input int n);
    set_lines(1'b1, 1'b1);
    set_lines(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      set_lines(1'b0, 1'b0);
      if (i != n - 1) set_lines(1'b0, 1'b1);
    end
    set_lines(1'b1, 1'b0);
  endtask

  // Sends the n low bits of v, MSB first, starting with phase A.
  task automatic send_bits(input logic [15:0] v, input int n);
    logic b;
    for (int j = 0; j < n; j++) begin
      b = v[n - 1 - j];
      if (j % 2 == 0) begin
        set_lines(1'b1, b);   // set up pin5 data with pin1 high
        set_lines(1'b0, b);   // pin1 falls
      end else begin
        set_lines(b, 1'b1);   // set up pin1 data with pin5 high
        set_lines(b, 1'b0);   // pin5 falls
      end
    end
  endtask

  // pin5 low with pin1 high, then n pin1 pulses, then pin5 high.
  task automatic send_end(input int n);
    set_lines(1'b1, 1'b1);
    set_lines(1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      set_lines(1'b0, 1'b0);
      set_lines(1'b1, 1'b0);
    end
    set_lines(1'b1, 1'b1);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  typedef struct {
    int         pulses;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         end_pulses;
    logic       exp_start;
    logic       exp_end;
    logic       exp_err;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] model_rx_data;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4, 2, 8'hA5, 8'h3C, 2, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3, 0, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{5, 0, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4, 1, 8'h00, 8'h00, 2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4, 2, 8'hFF, 8'h01, 2, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4, 0, 8'h00, 8'h00, 2, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4, 1, 8'h96, 8'h00, 3, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{4, 1, 8'h69, 8'h00, 1, 1'b1, 1'b0, 1'b1};
    model_rx_data = 8'h00;

    // Reset state with the lines idle high.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_pulses", int'({rx_valid, frame_start, frame_end, frame_error}), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_start) push(EV_START, 8'h00);
      if (vecs[i].nbytes >= 1) begin
        push(EV_BYTE, vecs[i].b0);
        model_rx_data = vecs[i].b0;
      end
      if (vecs[i].nbytes == 2) begin
        push(EV_BYTE, vecs[i].b1);
        model_rx_data = vecs[i].b1;
      end
      if (vecs[i].exp_end) push(EV_END, 8'h00);
      if (vecs[i].exp_err) push(EV_ERR, 8'h00);

      send_start(vecs[i].pulses);
      if (vecs[i].pulses == 4) begin
        send_bits({vecs[i].b0, vecs[i].b1} >> (8 * (2 - vecs[i].nbytes)), 8 * vecs[i].nbytes);
        send_end(vecs[i].end_pulses);
      end
      settle_and_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(model_rx_data));
    end

    // 12 bits, then pin5 falls while phase A is expected, off a byte boundary.
    push(EV_START, 8'h00);
    push(EV_BYTE, 8'hC3);
    push(EV_ERR, 8'h00);
    send_start(4);
    send_bits(16'h0C39, 12);
    set_lines(1'b1, 1'b1);
    set_lines(1'b1, 1'b0);
    settle_and_check("partial_end");

    // One byte, then the lines freeze. The byte's final edge also produces
    // rx_valid, so frame_error must follow rx_valid by exactly T cycles.
    push(EV_START, 8'h00);
    push(EV_BYTE, 8'h5A);
    push(EV_ERR, 8'h00);
    send_start(4);
    send_bits(16'h005A, 8);
    repeat (T + 40) @(posedge clk);
    @(negedge clk);
    chk("timeout_delay", last_err_cyc - last_valid_cyc, T);
    settle_and_check("timeout");

    // Drop enable mid-byte and toggle the lines: no pulses may appear.
    push(EV_START, 8'h00);
    send_start(4);
    send_bits(16'h0005, 3);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    set_lines(1'b0, 1'b1);
    set_lines(1'b1, 1'b1);
    set_lines(1'b0, 1'b0);
    set_lines(1'b1, 1'b0);
    set_lines(1'b1, 1'b1);
    settle_and_check("disabled");
    @(posedge clk);
    #1;
    enable = 1'b1;
    push(EV_START, 8'h00);
    push(EV_BYTE, 8'hFF);
    push(EV_END, 8'h00);
    send_start(4);
    send_bits(16'h00FF, 8);
    send_end(2);
    settle_and_check("reenabled");
    chk("reenabled_rx_data", int'(rx_data), 8'hFF);

    // One-cycle reset in the middle of a frame.
    push(EV_START, 8'h00);
    push(EV_BYTE, 8'h81);
    send_start(4);
    send_bits(16'h0081, 8);
    repeat (6) @(posedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_rx_data", int'(rx_data), 0);
    chk("midreset_pulses", int'({rx_valid, frame_start, frame_end, frame_error}), 0);
    chk("midreset_busy", int'(busy), 0);
    set_lines(1'b1, 1'b1);
    repeat (6) @(posedge clk);
    push(EV_START, 8'h00);
    push(EV_BYTE, 8'h00);
    push(EV_END, 8'h00);
    send_start(4);
    send_bits(16'h0000, 8);
    send_end(2);
    settle_and_check("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maple_rx.md
Name: maple_rx

Overview:
Maple bus frame receiver/decoder. Samples the selected port's SDCKA/SDCKB line levels (in_p1/in_p5 from the port mux) and detects start and end patterns. Decodes the alternating-phase bit stream into bytes and reports framing and timeout errors. It sits beside the transmitter and is held idle while the local side drives the bus.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each input line before edge detection (min 2)
TIMEOUT_CYCLES, 4096, clk cycles without any line edge before an in-frame abort
TMO_W, 13, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = receive; 0 = hold FSM in IDLE (local transmit in progress)
in_p1  input  1  raw level of selected pin1 (SDCKA), asynchronous
in_p5  input  1  raw level of selected pin5 (SDCKB), asynchronous
rx_data  output  8  last completed byte, MSB first on wire
rx_valid  output  1  1-cycle pulse, rx_data valid
frame_start  output  1  1-cycle pulse, valid start pattern seen
frame_end  output  1  1-cycle pulse, valid end pattern on byte boundary
frame_error  output  1  1-cycle pulse, framing violation or timeout
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE, synchronizers and previous-level regs=1 (bus idle high), rx_data=0, all pulses=0, busy=0, counters=0.
- Inputs pass through SYNC_STAGES flops. Let a1/a5 be the synchronized levels; fall1/fall5/rise1/rise5 are derived against the previous-cycle value.
- Bit sampling: phase A edge = fall1, data bit = a5. Phase B edge = fall5, data bit = a1. Bits shift in MSB first. Phases strictly alternate, starting with A after the start pattern.
- States:
  - IDLE: on fall1 with a5=1 -> START, pcnt=0.
  - START: fall5 -> pcnt+1, saturating at 7. On rise1: if pcnt==4, go to DATA, pulse frame_start, bitcnt=0, expect A. Otherwise pulse frame_error and go to IDLE. fall1 is not possible here (a1 is low).
  - DATA, expecting A:
    - fall1 -> shift a5, expect B.
    - fall5 with a1=1 and bitcnt==0 -> END, ecnt=0.
    - fall5 with bitcnt!=0 -> frame_error, IDLE.
  - DATA, expecting B:
    - fall5 -> shift a1, expect A.
    - fall1 -> frame_error, IDLE.
  - In DATA, fall1 and fall5 in the same cycle -> frame_error, IDLE.
  - Bit count: bitcnt is 3 bits and wraps 7->0. When bit 7 is shifted, rx_data is loaded and rx_valid pulses on the next cycle.
  - END: fall1 -> ecnt+1, saturating at 3. On rise5: if ecnt==2, pulse frame_end, else pulse frame_error; go to IDLE either way. Any fall5 in END cannot occur (a5 is low).
- Latency: raw wire edge to rx_valid, frame_start or frame_end = SYNC_STAGES+2 clk cycles.
- Timeout: the counter clears on any edge of a1/a5 and in IDLE. Outside IDLE it increments each cycle. On reaching TIMEOUT_CYCLES: pulse frame_error, go to IDLE.
- enable=0: next state IDLE, no pulses. A frame aborted this way produces no frame_error. Synchronizers keep running so edge history stays valid when enable returns.
- Ending a frame on a non-byte boundary (fall5 with bitcnt!=0 while expecting A) is an error, not an end.
- At most one of rx_valid/frame_start/frame_end/frame_error is high in any cycle. rx_data holds its value until the next byte completes.
- Back-to-back frames: IDLE accepts a new start on the cycle after returning.

Test Plan:
- Reset with lines high, then a start pattern (pin1 low, 4 pin5 pulses, pin1 high), bytes 0xA5, 0x3C, then an end pattern (pin5 low, 2 pin1 pulses, pin5 high) -> frame_start; rx_valid with 0xA5 then 0x3C; frame_end; no frame_error; busy back to 0.
- Start pattern with 3 pin5 pulses -> frame_error on pin1 rise, no frame_start, returns to IDLE. Repeat with 5 pulses -> same result.
- Valid start, 12 bits, then pin5 falls while phase A is expected -> frame_error, one rx_valid (first byte only), no frame_end.
- Valid start and 1 byte, then lines frozen -> frame_error exactly TIMEOUT_CYCLES cycles after the last edge; busy=0 afterwards.
- Drop enable mid-byte, toggle lines, raise enable, send a full valid frame with 0xFF -> no pulses while disabled; then frame_start, rx_valid 0xFF, frame_end.
- Assert rst_n=0 for one cycle mid-frame -> all outputs 0 and busy=0 next cycle; a following valid frame with 0x00 decodes correctly.
